key_debounce_multi: RTL and testbench

Parametrised multi-channel push-button conditioner, the next generation of the single-key 20 ms debouncer. Each channel synchronises a raw key input, debounces both press and release edges with a configurable time, and emits a stable level plus one-cycle press, release and long-press pulses. It sits between board key pins and any control logic, such as menu FSMs or counters, that needs clean per-key events.

---
 rtl/key_debounce_multi.sv | 162 ++++++++++++++++
 tb/tb_key_debounce_multi.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_multi.sv
// Multi-channel push-button conditioner: per key a 2-flop synchroniser, polarity
// normalisation and a debounce FSM producing a stable level plus press/release/long pulses.
module key_debounce_multi #(
  parameter int CHANNELS      = 4,
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 1000,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                sclk,
  input  logic                nrst,
  input  logic [CHANNELS-1:0] key_in,
  output logic [CHANNELS-1:0] key_level,
  output logic [CHANNELS-1:0] key_press,
  output logic [CHANNELS-1:0] key_release,
  output logic [CHANNELS-1:0] key_long
);

  localparam int DEB_CYC  = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
  localparam int LONG_CYC = CLK_FREQ_HZ / 1000 * LONG_PRESS_MS;
  localparam int DW       = $clog2(DEB_CYC) + 1;
  localparam int LW       = $clog2(LONG_CYC) + 1;

  localparam bit            LONG_EN   = (LONG_PRESS_MS != 0);
  localparam logic          REL_LVL   = (ACTIVE_LOW != 0);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYC - 1);
  localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYC);

  if (DEB_CYC < 2) begin : g_bad_deb
    $error("key_debounce_multi: debounce time must be at least 2 clock cycles");
  end
  if (LONG_EN && (LONG_PRESS_MS <= DEBOUNCE_MS)) begin : g_bad_long
    $error("key_debounce_multi: long-press time must exceed debounce time");
  end
  if ((CHANNELS < 1) || (CHANNELS > 32)) begin : g_bad_ch
    $error("key_debounce_multi: CHANNELS must be in 1..32");
  end

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_PRESS_DEB   = 2'd1,
    ST_HELD        = 2'd2,
    ST_RELEASE_DEB = 2'd3
  } state_t;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic          r_sync0;
    logic          r_sync1;
    logic          w_p;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_dcnt;
    logic [DW-1:0] w_dcnt_nxt;
    logic [LW-1:0] r_lcnt;
    logic [LW-1:0] w_lcnt_nxt;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          r_long;
    logic          w_level_nxt;
    logic          w_press_nxt;
    logic          w_release_nxt;
    logic          w_long_nxt;

    // Synchroniser resets to the released pin level so a held key is re-debounced.
    always_ff @(posedge sclk or negedge nrst) begin
      if (!nrst) begin
        r_sync0 <= REL_LVL;
        r_sync1 <= REL_LVL;
      end else begin
        r_sync0 <= key_in[g];
        r_sync1 <= r_sync0;
      end
    end

    assign w_p = r_sync1 ^ REL_LVL;

    always_ff @(posedge sclk or negedge nrst) begin
      if (!nrst) begin
        r_state   <= ST_IDLE;
        r_dcnt    <= '0;
        r_lcnt    <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_dcnt    <= w_dcnt_nxt;
        r_lcnt    <= w_lcnt_nxt;
        r_level   <= w_level_nxt;
        r_press   <= w_press_nxt;
        r_release <= w_release_nxt;
        r_long    <= w_long_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_dcnt_nxt  = r_dcnt;
      w_lcnt_nxt  = r_lcnt;
      case (r_state)
        ST_IDLE: begin
          w_dcnt_nxt = '0;
          if (w_p) begin
            w_state_nxt = ST_PRESS_DEB;
            w_dcnt_nxt  = DW'(1);
          end
        end
        ST_PRESS_DEB: begin
          if (!w_p) begin
            w_state_nxt = ST_IDLE;
            w_dcnt_nxt  = '0;
          end else if (r_dcnt == DEB_LAST) begin
            w_state_nxt = ST_HELD;
            w_dcnt_nxt  = '0;
            w_lcnt_nxt  = '0;
          end else begin
            w_dcnt_nxt = r_dcnt + 1'b1;
          end
        end
        ST_HELD: begin
          // Saturating at LONG_MAX is what keeps key_long to one pulse per press.
          if (r_lcnt != LONG_MAX) w_lcnt_nxt = r_lcnt + 1'b1;
          if (!w_p) begin
            w_state_nxt = ST_RELEASE_DEB;
            w_dcnt_nxt  = DW'(1);
          end
        end
        ST_RELEASE_DEB: begin
          if (w_p) begin
            w_state_nxt = ST_HELD;
            w_dcnt_nxt  = '0;
          end else if (r_dcnt == DEB_LAST) begin
            w_state_nxt = ST_IDLE;
            w_dcnt_nxt  = '0;
          end else begin
            w_dcnt_nxt = r_dcnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_dcnt_nxt  = '0;
        end
      endcase
    end

    always_comb begin
      w_press_nxt   = (r_state == ST_PRESS_DEB) && w_p && (r_dcnt == DEB_LAST);
      w_release_nxt = (r_state == ST_RELEASE_DEB) && !w_p && (r_dcnt == DEB_LAST);
      w_long_nxt    = LONG_EN && (r_state == ST_HELD) && (r_lcnt == LONG_LAST);
      w_level_nxt   = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_RELEASE_DEB);
    end

    assign key_level[g]   = r_level;
    assign key_press[g]   = r_press;
    assign key_release[g] = r_release;
    assign key_long[g]    = r_long;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: active-low and active-high instances driven with the same
// key activity, checked every cycle against a run-length model and at hand-computed cycles.
module tb_key_debounce_multi;

  localparam int DEB  = 20;
  localparam int LONG = 100;

  logic       clk;
  logic       nrst;
  logic [3:0] pressed;
  logic [3:0] key_a;
  logic [3:0] key_b;
  logic [3:0] level_a, press_a, release_a, long_a;
  logic [3:0] level_b, press_b, release_b, long_b;

  int checks   = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  assign key_a = ~pressed;
  assign key_b = pressed;

  key_debounce_multi #(
    .CHANNELS(4), .CLK_FREQ_HZ(10_000), .DEBOUNCE_MS(2), .LONG_PRESS_MS(10), .ACTIVE_LOW(1)
  ) u_dut_low (
    .sclk(clk), .nrst(nrst), .key_in(key_a),
    .key_level(level_a), .key_press(press_a), .key_release(release_a), .key_long(long_a)
  );

  key_debounce_multi #(
    .CHANNELS(4), .CLK_FREQ_HZ(10_000), .DEBOUNCE_MS(2), .LONG_PRESS_MS(10), .ACTIVE_LOW(0)
  ) u_dut_high (
    .sclk(clk), .nrst(nrst), .key_in(key_b),
    .key_level(level_b), .key_press(press_b), .key_release(release_b), .key_long(long_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: the key as seen two samples late must disagree with the level for DEB
  // consecutive cycles to flip it; held time counts only while not debouncing a release.
  logic [3:0] m_d1, m_d2, m_level, m_press, m_release, m_long;
  logic       m_seen;
  int         m_run[4];
  int         m_hold[4];

  initial begin
    m_d1 = '0; m_d2 = '0; m_level = '0; m_press = '0; m_release = '0; m_long = '0;
    for (int c = 0; c < 4; c++) begin m_run[c] = 0; m_hold[c] = 0; end
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) begin
        m_d1 = '0; m_d2 = '0; m_level = '0; m_press = '0; m_release = '0; m_long = '0;
        for (int c = 0; c < 4; c++) begin m_run[c] = 0; m_hold[c] = 0; end
      end else begin
        m_press = '0; m_release = '0; m_long = '0;
        for (int c = 0; c < 4; c++) begin
          m_seen  = m_d2[c];
          m_d2[c] = m_d1[c];
          m_d1[c] = pressed[c];
          if (m_level[c] && m_run[c] == 0) begin
            if (m_hold[c] == LONG - 1) m_long[c] = 1'b1;
            if (m_hold[c] < LONG) m_hold[c]++;
          end
          if (m_seen != m_level[c]) begin
            m_run[c]++;
            if (m_run[c] == DEB) begin
              m_run[c] = 0;
              if (m_level[c]) m_release[c] = 1'b1;
              else begin m_press[c] = 1'b1; m_hold[c] = 0; end
              m_level[c] = ~m_level[c];
            end
          end else begin
            m_run[c] = 0;
          end
        end
      end
    end
  end

  // Per-cycle scoreboard compare, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("cmp_level_a", level_a, m_level);
        chk("cmp_press_a", press_a, m_press);
        chk("cmp_release_a", release_a, m_release);
        chk("cmp_long_a", long_a, m_long);
        chk("cmp_level_b", level_b, m_level);
        chk("cmp_press_b", press_b, m_press);
        chk("cmp_release_b", release_b, m_release);
        chk("cmp_long_b", long_b, m_long);
      end
    end
  end

  // Directed stimulus with literal expectations
  initial begin
    nrst    = 1'b1;
    pressed = '0;
    #1 nrst = 1'b0;
    tick(3);
    cmp_en = 1'b1;
    chk("rst_level", level_a, 4'b0000);
    chk("rst_press", press_a | press_b, 4'b0000);
    nrst = 1'b1;
    tick(5);

    // Steady press on ch0
    pressed[0] = 1'b1;
    tick(DEB + 1);
    chk("t1_press_early", press_a, 4'b0000);
    chk("t1_level_early", level_a, 4'b0000);
    tick(1);
    chk("t1_press_a", press_a, 4'b0001);
    chk("t1_press_b", press_b, 4'b0001);
    chk("t1_level_a", level_a, 4'b0001);
    tick(1);
    chk("t1_press_width", press_a, 4'b0000);

    // Long press on ch0: 100 cycles after the press cycle
    tick(LONG - 2);
    chk("t3_long_early", long_a, 4'b0000);
    tick(1);
    chk("t3_long_a", long_a, 4'b0001);
    chk("t3_long_b", long_b, 4'b0001);
    tick(1);
    chk("t3_long_width", long_a, 4'b0000);
    tick(50);

    // Press bounce on ch1
    for (int i = 0; i < 5; i++) begin
      pressed[1] = 1'b1;
      tick(19);
      chk("t2_bounce_press", press_a, 4'b0000);
      pressed[1] = 1'b0;
      tick(1);
    end
    pressed[1] = 1'b1;
    tick(DEB + 1);
    chk("t2_press_early", press_a, 4'b0000);
    tick(1);
    chk("t2_press_a", press_a, 4'b0010);
    chk("t2_level_a", level_a, 4'b0011);

    // Release bounce on held ch0
    pressed[0] = 1'b0;
    tick(10);
    pressed[0] = 1'b1;
    tick(30);
    chk("t4_bounce_level", level_a, 4'b0011);
    pressed[0] = 1'b0;
    tick(DEB + 1);
    chk("t4_release_early", release_a, 4'b0000);
    chk("t4_level_early", level_a, 4'b0011);
    tick(1);
    chk("t4_release_a", release_a, 4'b0001);
    chk("t4_release_b", release_b, 4'b0001);
    chk("t4_level_a", level_a, 4'b0010);

    // ch2 press and ch3 release on the same edge
    pressed[3] = 1'b1;
    tick(30);
    pressed[2] = 1'b1;
    pressed[3] = 1'b0;
    tick(DEB + 2);
    chk("t5_press", press_a, 4'b0100);
    chk("t5_release", release_a, 4'b1000);
    chk("t5_level", level_a, 4'b0110);

    // Reset while ch1/ch2 are held
    tick(5);
    nrst = 1'b0;
    #2;
    chk("t6_rst_level_a", level_a, 4'b0000);
    chk("t6_rst_level_b", level_b, 4'b0000);
    tick(2);
    nrst = 1'b1;
    tick(DEB + 1);
    chk("t6_press_early", press_a, 4'b0000);
    tick(1);
    chk("t6_press_a", press_a, 4'b0110);
    chk("t6_press_b", press_b, 4'b0110);
    chk("t6_level_a", level_a, 4'b0110);

    pressed = '0;
    tick(30);
    chk("end_level", level_a | level_b, 4'b0000);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
